// File: rtl/uart_rx_fsm_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : uart_rx_fsm_if                                                |
// | Desc   : RX line, checker results and FSM strobes for uart_rx_fsm;     |
// |          frame_err exists only when UART_RX_FRAME_ERR_EN is defined.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  strt_glitch;
  logic                  par_error;
  logic                  stop_error;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  data_samp_EN;
  logic                  deser_EN;
  logic                  strt_check_EN;
  logic                  par_check_EN;
  logic                  stop_check_EN;
  logic                  data_valid;

`ifdef UART_RX_FRAME_ERR_EN
  logic                  frame_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, strt_glitch, par_error, stop_error,
    input  edge_cnt, bit_cnt, data_samp_EN, deser_EN, strt_check_EN,
           par_check_EN, stop_check_EN, data_valid, frame_err
  );
  modport slave (
    input  RX_IN, Prescale, PAR_EN, strt_glitch, par_error, stop_error,
    output edge_cnt, bit_cnt, data_samp_EN, deser_EN, strt_check_EN,
           par_check_EN, stop_check_EN, data_valid, frame_err
  );
`else
  modport master (
    output RX_IN, Prescale, PAR_EN, strt_glitch, par_error, stop_error,
    input  edge_cnt, bit_cnt, data_samp_EN, deser_EN, strt_check_EN,
           par_check_EN, stop_check_EN, data_valid
  );
  modport slave (
    input  RX_IN, Prescale, PAR_EN, strt_glitch, par_error, stop_error,
    output edge_cnt, bit_cnt, data_samp_EN, deser_EN, strt_check_EN,
           par_check_EN, stop_check_EN, data_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : uart_rx_fsm                                                   |
// | Desc   : UART receiver control FSM; UART_RX_FRAME_ERR_EN adds frame_err.|
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic          CLK,
  input  logic          Reset,
  uart_rx_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] C_LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  par_en_q;
  logic                  err_q;

  logic [PRESCALE_W-1:0] w_chk;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_at_chk;
  logic                  w_at_chk1;
  logic                  w_at_wrap;
  logic                  w_deser_en;
  logic                  w_strt_chk_en;
  logic                  w_par_chk_en;
  logic                  w_stop_chk_en;
  logic                  w_data_valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic                  w_frame_err;
`endif

  // CHK is the edge where the sampler's 3-sample majority around mid-bit is complete
  assign w_chk     = (bus.Prescale >> 1) + PRESCALE_W'(2);
  assign w_last    = bus.Prescale - PRESCALE_W'(1);
  assign w_at_chk  = (r_edge_cnt == w_chk);
  assign w_at_chk1 = (r_edge_cnt == (w_chk + PRESCALE_W'(1)));
  assign w_at_wrap = (r_edge_cnt == w_last);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_deser_en    = 1'b0;
    w_strt_chk_en = 1'b0;
    w_par_chk_en  = 1'b0;
    w_stop_chk_en = 1'b0;
    w_data_valid  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    w_frame_err   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!bus.RX_IN) w_next_state = START;
      end
      START: begin
        w_strt_chk_en = w_at_chk;
        if (w_at_chk1 && bus.strt_glitch) w_next_state = IDLE;
        else if (w_at_wrap)               w_next_state = DATA;
      end
      DATA: begin
        w_deser_en = w_at_chk;
        if (w_at_wrap && (r_bit_cnt == C_LAST_DATA_BIT))
          w_next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        w_par_chk_en = w_at_chk;
        if (w_at_wrap) w_next_state = STOP;
      end
      STOP: begin
        w_stop_chk_en = w_at_chk;
        // Leave early so a start bit arriving right after mid-stop is not missed
        if (w_at_chk1) begin
          w_next_state = IDLE;
          w_data_valid = !bus.stop_error && !err_q;
`ifdef UART_RX_FRAME_ERR_EN
          w_frame_err  = bus.stop_error || err_q;
`endif
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if ((r_state == IDLE) || (w_next_state == IDLE)) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_at_wrap) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      par_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if ((r_state == IDLE) && !bus.RX_IN) par_en_q <= bus.PAR_EN;
      if ((r_state == PARITY) && w_at_chk1)    err_q <= bus.par_error;
      else if ((r_state == STOP) && w_at_chk1) err_q <= 1'b0;
    end
  end

  assign bus.edge_cnt      = r_edge_cnt;
  assign bus.bit_cnt       = r_bit_cnt;
  assign bus.data_samp_EN  = (r_state != IDLE);
  assign bus.deser_EN      = w_deser_en;
  assign bus.strt_check_EN = w_strt_chk_en;
  assign bus.par_check_EN  = w_par_chk_en;
  assign bus.stop_check_EN = w_stop_chk_en;
  assign bus.data_valid    = w_data_valid;
`ifdef UART_RX_FRAME_ERR_EN
  assign bus.frame_err     = w_frame_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_uart_rx_fsm                                                |
// | Desc   : frame-level directed vectors and reset corner cases           |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_uart_rx_fsm;

  localparam int PW = 6;

  typedef struct packed {
    logic [5:0] prescale;
    logic       par;
    logic       glitch;
    logic       perr;
    logic       serr;
    logic [7:0] data;
    logic [3:0] gap;
    logic [3:0] e_deser;
    logic       e_par;
    logic       e_stop;
    logic       e_dv;
    logic       e_fe;
    logic [5:0] e_chk;
    logic [3:0] e_stop_bit;
    logic [9:0] e_len;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [0:9];
  vec_t rv;

  uart_rx_fsm_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_fsm #(
    .DATA_WIDTH (8),
    .PRESCALE_W (PW)
  ) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_bit(input vec_t v, input int c);
    int         b;
    logic [7:0] d;
    d = v.data;
    if (v.glitch) return (c < 3) ? 1'b0 : 1'b1;
    b = c / int'(v.prescale);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (v.par && (b == 9)) return ^d;
    return 1'b1;
  endfunction

  // Entered and left inside a cycle with inputs already applied, so frames chain back-to-back
  task automatic run_frame(input vec_t v, input int idx);
    int          active, strt_n, deser_n, par_n, stop_n, dv_n, bad_edge, multi;
    int          par_bit, stop_bit, dv_bit, dv_edge;
    logic [15:0] mask;
    logic        p_strt, p_par, p_stop, done;
`ifdef UART_RX_FRAME_ERR_EN
    int          fe_n;
    fe_n = 0;
`endif
    active = 0; strt_n = 0; deser_n = 0; par_n = 0; stop_n = 0; dv_n = 0;
    bad_edge = 0; multi = 0; par_bit = -1; stop_bit = -1; dv_bit = -1; dv_edge = -1;
    mask = '0; p_strt = 0; p_par = 0; p_stop = 0; done = 0;

    for (int g = 0; g < int'(v.gap); g++) begin
      bus.RX_IN = 1'b1;
      step();
    end
    bus.Prescale = v.prescale;
    bus.PAR_EN = v.par;
    bus.RX_IN = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_error = 1'b0;
    bus.stop_error = 1'b0;
    #1;
    check($sformatf("v%0d.idle_at_start", idx), int'(bus.data_samp_EN), 0);

    for (int c = 1; c < 400; c++) begin
      step();
      bus.PAR_EN      = ~v.par;
      bus.RX_IN       = line_bit(v, c);
      bus.strt_glitch = p_strt & v.glitch;
      bus.par_error   = p_par & v.perr;
      bus.stop_error  = p_stop & v.serr;
      #1;
      if (!bus.data_samp_EN) begin
        done = 1;
        break;
      end
      active++;
      if ($countones({bus.deser_EN, bus.strt_check_EN, bus.par_check_EN, bus.stop_check_EN}) > 1)
        multi++;
      if (bus.strt_check_EN) begin
        strt_n++;
        if ((int'(bus.edge_cnt) != int'(v.e_chk)) || (bus.bit_cnt != 4'd0)) bad_edge++;
      end
      if (bus.deser_EN) begin
        deser_n++;
        mask[bus.bit_cnt] = 1'b1;
        if (int'(bus.edge_cnt) != int'(v.e_chk)) bad_edge++;
      end
      if (bus.par_check_EN) begin
        par_n++;
        par_bit = int'(bus.bit_cnt);
        if (int'(bus.edge_cnt) != int'(v.e_chk)) bad_edge++;
      end
      if (bus.stop_check_EN) begin
        stop_n++;
        stop_bit = int'(bus.bit_cnt);
        if (int'(bus.edge_cnt) != int'(v.e_chk)) bad_edge++;
      end
      if (bus.data_valid) begin
        dv_n++;
        dv_bit  = int'(bus.bit_cnt);
        dv_edge = int'(bus.edge_cnt);
      end
`ifdef UART_RX_FRAME_ERR_EN
      if (bus.frame_err) fe_n++;
`endif
      p_strt = bus.strt_check_EN;
      p_par  = bus.par_check_EN;
      p_stop = bus.stop_check_EN;
    end

    check($sformatf("v%0d.returned_idle", idx), int'(done), 1);
    check($sformatf("v%0d.active_len", idx), active, int'(v.e_len));
    check($sformatf("v%0d.strt_cnt", idx), strt_n, 1);
    check($sformatf("v%0d.deser_cnt", idx), deser_n, int'(v.e_deser));
    check($sformatf("v%0d.deser_bits", idx), int'(mask),
          (v.e_deser != 4'd0) ? 32'h01FE : 32'h0000);
    check($sformatf("v%0d.strobe_edge", idx), bad_edge, 0);
    check($sformatf("v%0d.multi_en", idx), multi, 0);
    check($sformatf("v%0d.par_cnt", idx), par_n, int'(v.e_par));
    check($sformatf("v%0d.stop_cnt", idx), stop_n, int'(v.e_stop));
    check($sformatf("v%0d.dv_cnt", idx), dv_n, int'(v.e_dv));
    if (v.e_par)
      check($sformatf("v%0d.par_bit", idx), par_bit, int'(v.e_stop_bit) - 1);
    if (v.e_stop)
      check($sformatf("v%0d.stop_bit", idx), stop_bit, int'(v.e_stop_bit));
    if (v.e_dv) begin
      check($sformatf("v%0d.dv_bit", idx), dv_bit, int'(v.e_stop_bit));
      check($sformatf("v%0d.dv_edge", idx), dv_edge, int'(v.e_chk) + 1);
    end
`ifdef UART_RX_FRAME_ERR_EN
    check($sformatf("v%0d.fe_cnt", idx), fe_n, int'(v.e_fe));
`endif
  endtask

  initial begin
    //            P     par   gl    perr  serr  data   gap   deser par  stop dv   fe   chk    sbit  len
    vecs[0] = '{6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd2, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 6'd6,  4'd9,  10'd80};
    vecs[1] = '{6'd16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 4'd0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 6'd10, 4'd10, 10'd172};
    vecs[2] = '{6'd8,  1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 6'd6,  4'd10, 10'd88};
    vecs[3] = '{6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 6'd6,  4'd9,  10'd80};
    vecs[4] = '{6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd3, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 6'd18, 4'd9,  10'd308};
    vecs[5] = '{6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 6'd18, 4'd9,  10'd308};
    vecs[6] = '{6'd8,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6,  4'd0,  10'd8};
    vecs[7] = '{6'd16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd10, 4'd0,  10'd12};
    vecs[8] = '{6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 4'd0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 6'd10, 4'd9,  10'd156};
    vecs[9] = '{6'd8,  1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 6'd6,  4'd10, 10'd88};
    rv      = '{6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 4'd2, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 6'd6,  4'd9,  10'd80};

    bus.RX_IN       = 1'b1;
    bus.Prescale    = 6'd8;
    bus.PAR_EN      = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_error   = 1'b0;
    bus.stop_error  = 1'b0;
    #2;
    check("rst.data_samp_EN", int'(bus.data_samp_EN), 0);
    check("rst.edge_cnt", int'(bus.edge_cnt), 0);
    check("rst.bit_cnt", int'(bus.bit_cnt), 0);
    check("rst.enables", int'({bus.deser_EN, bus.strt_check_EN, bus.par_check_EN,
                               bus.stop_check_EN, bus.data_valid}), 0);
    bus.RX_IN = 1'b0;
    step();
    step();
    check("rst.held_low_line", int'(bus.data_samp_EN), 0);
    bus.RX_IN = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

    // Abort mid-frame with an asynchronous reset during data bit 4
    begin
      logic reached;
      reached = 1'b0;
      bus.Prescale = 6'd8;
      bus.PAR_EN   = 1'b0;
      bus.RX_IN    = 1'b0;
      for (int c = 1; c < 100; c++) begin
        step();
        bus.RX_IN = line_bit(rv, c);
        #1;
        if (bus.data_samp_EN && (bus.bit_cnt == 4'd4) && (bus.edge_cnt == 6'd3)) begin
          reached = 1'b1;
          break;
        end
      end
      check("abort.reached_bit4", int'(reached), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort.data_samp_EN", int'(bus.data_samp_EN), 0);
      check("abort.edge_cnt", int'(bus.edge_cnt), 0);
      check("abort.bit_cnt", int'(bus.bit_cnt), 0);
      check("abort.enables", int'({bus.deser_EN, bus.strt_check_EN, bus.par_check_EN,
                                   bus.stop_check_EN, bus.data_valid}), 0);
      bus.RX_IN = 1'b1;
      step();
      rst_n = 1'b1;
    end
    run_frame(rv, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control FSM of the UART receiver.
- Tracks oversampling edges and bit position for each incoming frame.
- Generates one-cycle enables for the data sampler, deserializer, start/parity/stop checkers.
- Consumes the checkers' registered error flags and issues a one-cycle data_valid for error-free frames.
- Sits between the RX line synchroniser and the checker/deserializer stages. The stop-bit checker is directly downstream: it is driven by stop_check_EN and returns stop_error.

Parameters:
- DATA_WIDTH, 8, data bits per frame (supported range 5..9).
- PRESCALE_W, 6, width of Prescale and edge_cnt.

Ports:
- CLK  input  1  oversampling clock.
- Reset  input  1  asynchronous, active-low reset.
- RX_IN  input  1  synchronised serial line; idle high.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; static while a frame is in flight.
- PAR_EN  input  1  frame contains a parity bit; sampled in IDLE only.
- strt_glitch  input  1  registered start-check result; valid the cycle after strt_check_EN.
- par_error  input  1  registered parity-check result; valid the cycle after par_check_EN.
- stop_error  input  1  registered stop-check result; valid the cycle after stop_check_EN.
- edge_cnt  output  PRESCALE_W  current oversampling edge within the bit, 0..Prescale-1.
- bit_cnt  output  4  current bit index within the frame (start = 0).
- data_samp_EN  output  1  sampler enable; high in all states except IDLE.
- deser_EN  output  1  one-cycle shift strobe for the deserializer.
- strt_check_EN  output  1  one-cycle start-check strobe.
- par_check_EN  output  1  one-cycle parity-check strobe.
- stop_check_EN  output  1  one-cycle stop-check strobe.
- data_valid  output  1  one-cycle frame-accepted pulse.

Behaviour:

Reset
- All outputs reset to 0. State resets to IDLE. edge_cnt = 0, bit_cnt = 0.
- Reset asserted mid-frame aborts the frame immediately, with no data_valid.

Definitions
- H = Prescale >> 1.
- CHK = H + 2, the edge at which the 3-sample majority is complete.

Edge counter
- Increments every cycle outside IDLE.
- At Prescale-1 it wraps to 0 and bit_cnt increments.
- In IDLE, edge_cnt = bit_cnt = 0.

States and transitions
- IDLE: when RX_IN = 0, go to START. PAR_EN is latched into par_en_q on this transition.
- START: strt_check_EN is high at edge CHK. At CHK+1:
  - strt_glitch = 1: return to IDLE and clear the counters.
  - otherwise: continue. At the wrap, go to DATA.
- DATA: deser_EN is high at edge CHK of each data bit. After bit DATA_WIDTH wraps:
  - par_en_q = 1: go to PARITY.
  - otherwise: go to STOP.
- PARITY: par_check_EN is high at edge CHK. At CHK+1, par_error is captured into err_q. At the wrap, go to STOP.
- STOP: stop_check_EN is high at edge CHK. At CHK+1:
  - stop_error = 0 and err_q = 0: data_valid = 1 for exactly this cycle.
  - Either way, go to IDLE. err_q is cleared.
- The FSM does not wait for the remainder of the stop bit. A new start edge can be accepted from edge CHK+2 of the stop bit onward.

Error handling
- Each enable is high for exactly one cycle per bit. At most one enable is high in any cycle.
- Parity error: frame is dropped silently, with no data_valid.
- Stop error: same.

Boundaries
- RX_IN low in IDLE on the cycle right after a stop-bit exit is accepted as a new start.
- Illegal Prescale values (anything but 8/16/32) are undefined and are not checked in RTL.

Optional Feature:
Macro UART_RX_FRAME_ERR_EN.
- Defined: adds output port frame_err (1 bit, reset 0). It pulses for one cycle at STOP edge CHK+1 when stop_error or err_q is set, i.e. in the cycle where data_valid would have fired.
- Undefined: no port, no logic. Errored frames are dropped silently.

Test Plan:
- Prescale=8, PAR_EN=0, clean frame 0xA5 with stop=1 -> deser_EN pulses 8 times at edge 6 of bits 1..8; stop_check_EN at bit 9, edge 6; data_valid=1 at the next cycle.
- Prescale=16, PAR_EN=1, correct parity, byte 0x3C -> par_check_EN at bit 9, edge 10; stop_check_EN at bit 10, edge 10; data_valid pulses once.
- Prescale=8, PAR_EN=1, par_error=1 returned -> no data_valid; FSM reaches IDLE after the stop bit; frame_err=1 for one cycle when macro is defined.
- Prescale=32, stop_error=1 returned -> data_valid stays 0; FSM in IDLE at STOP edge 19; the next frame's start at edge 20 is accepted.
- RX_IN low for 3 cycles then high, with strt_glitch=1 returned -> FSM back in IDLE at START edge CHK+1; no deser_EN ever asserted.
- Reset driven low during DATA bit 4 -> all outputs are 0 the same cycle; after release, a clean frame 0x5A yields data_valid normally.
